rv_multicycle_control: RTL and testbench
========================================

// Module: rv_multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core; sits directly upstream of the ALU control unit.
//  Sequences each instruction through fetch/decode/execute/memory/writeback.
//  Drives datapath mux selects and write strobes, and the 2-bit alu_op consumed downstream:
//    00 = add, 01 = branch compare, 10 = R-type, 11 = I-type ALU.
//  Handshakes with a variable-latency unified memory; flags illegal opcodes and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  255  max wait cycles per memory access before trap; 0 disables the timeout
// PORTS
//  clk            in   1  single clock, all state updates on rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  opcode         in   7  instr[6:0] from instruction register
//  funct3         in   3  instr[14:12] from instruction register
//  alu_zero       in   1  ALU result == 0 (combinational, current cycle)
//  alu_lt         in   1  ALU result bit 0 (SLT/SLTU outcome)
//  mem_ready      in   1  memory completes the current access this cycle
//  mem_read       out  1  read request; held until mem_ready
//  mem_write      out  1  write request; held until mem_ready
//  iord           out  1  address select: 0 = PC, 1 = ALUOut
//  ir_write       out  1  latch instruction register and old_pc
//  pc_write       out  1  update PC
//  pc_src         out  1  PC source: 0 = ALU result, 1 = ALUOut
//  reg_write      out  1  register file write enable
//  result_src     out  2  rd source: 00 = ALUOut, 01 = memory data, 10 = PC
//  alu_src_a      out  2  00 = PC, 01 = old_pc, 10 = rs1 reg, 11 = zero
//  alu_src_b      out  2  00 = rs2 reg, 01 = imm, 10 = constant 4
//  alu_op         out  2  to ALU control unit (encoding as in PURPOSE)
//  illegal_instr  out  1  sticky; opcode trap
//  bus_error      out  1  sticky; memory timeout trap
//  state_o        out  4  current state (debug)
// BEHAVIOUR
//  Reset (async): state = FETCH; wait counter = 0; illegal_instr = bus_error = 0.
//   All strobes (mem_*, *_write) are forced 0 while rst_n = 0.
//   First fetch request is issued in the first cycle after deassertion.
//  Outputs are Moore-decoded from state, except the strobes qualified by mem_ready or by branch taken.
//  FETCH: mem_read=1, iord=0, src_a=PC, src_b=4, op=00.
//   On mem_ready: ir_write=1 and pc_write=1 (pc_src=0), then -> DECODE. Otherwise stay.
//  DECODE: src_a=old_pc, src_b=imm, op=00 (target into ALUOut). Next state by opcode:
//   0110011 -> EXEC_R;  0010011 -> EXEC_I;  0000011 / 0100011 -> MEM_ADDR;  1100011 -> BRANCH
//   1101111 -> JAL;  1100111 -> JALR;  0110111 -> LUI;  0010111 -> AUIPC
//   0001111 (FENCE) -> FETCH, treated as a no-op;  any other opcode -> TRAP
//  EXEC_R: rs1 / rs2, op=10 -> WB_ALU.      EXEC_I: rs1 / imm, op=11 -> WB_ALU.
//  LUI: zero / imm, op=00 -> WB_ALU.        AUIPC: old_pc / imm, op=00 -> WB_ALU.
//  MEM_ADDR: rs1 / imm, op=00 -> MEM_LOAD if opcode[5]=0, else MEM_STORE.
//  MEM_LOAD: mem_read=1, iord=1; on mem_ready -> WB_MEM.
//  MEM_STORE: mem_write=1, iord=1; on mem_ready -> FETCH.
//  WB_ALU: reg_write=1, result_src=00 -> FETCH.   WB_MEM: reg_write=1, result_src=01 -> FETCH.
//  BRANCH: rs1 / rs2, op=01.
//   taken = funct3[0] ^ (funct3[2] ? alu_lt : alu_zero).
//   pc_write = taken, pc_src=1; -> FETCH. funct3 010/011 count as not taken.
//  JAL: reg_write=1, result_src=10 (PC already holds PC+4); pc_write=1, pc_src=1 -> FETCH.
//  JALR: rs1 / imm, op=00; pc_write=1, pc_src=0; reg_write=1, result_src=10 -> FETCH.
//   rd receives the pre-edge PC value.
//  TRAP: all strobes 0; illegal_instr=1; terminal until reset.
//  Wait counter: increments each cycle a request is held with mem_ready=0; clears on mem_ready or state exit.
//   When MEM_TIMEOUT != 0 and counter == MEM_TIMEOUT with mem_ready still 0: bus_error=1, -> TRAP.
//   mem_ready in that same cycle wins: the access completes and no error is raised.
//  Zero-wait cycle counts: R / I / LUI / AUIPC = 4, load = 5, store = 4, branch / JAL / JALR = 3.
// STRUCTURE
//  rv32i_pkg: opcode localparams, state enum (4-bit), alu_op codes, src_a / src_b / result_src encodings.
//  Sub-module rv_branch_eval: (funct3, alu_zero, alu_lt) -> taken; combinational.
//  Top level holds state register, wait counter, sticky flags and output decode.
// TESTING
//  1. Reset, opcode=0110011, mem_ready=1 always
//     -> states FETCH, DECODE, EXEC_R, WB_ALU; alu_op=10 in EXEC_R; reg_write=1 only in cycle 4.
//  2. Load (0000011) with mem_ready low 3 cycles in MEM_LOAD
//     -> mem_read and iord=1 held 4 cycles; WB_MEM follows; total 8 cycles.
//  3. BEQ (funct3=000), alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH.
//     BNE (funct3=001), alu_zero=1 -> pc_write=0.
//  4. BLTU (funct3=110), alu_lt=1 -> taken; BGEU (funct3=111), alu_lt=1 -> not taken; alu_op=01 both.
//  5. opcode=1110011 -> TRAP, illegal_instr=1, no strobes for 20 cycles;
//     rst_n pulse low -> FETCH, flag cleared.
//  6. MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_error=1 on wait cycle 5, TRAP.
//     mem_ready=1 on wait cycle 5 instead -> normal DECODE.
//  7. Async reset asserted mid-MEM_STORE -> mem_write drops immediately; state_o=FETCH.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states, mux selects.
package rv32i_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_LOAD  = 4'd3,
        S_WB_MEM    = 4'd4,
        S_MEM_STORE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_WB_ALU    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_AUIPC     = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    localparam logic [SEL_W-1:0] ALU_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALU_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] ALU_RTYPE  = 2'b10;
    localparam logic [SEL_W-1:0] ALU_ITYPE  = 2'b11;

    localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;
    localparam logic [SEL_W-1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
    localparam logic [SEL_W-1:0] RES_PC     = 2'b10;

    // States that hold a request on the unified memory port.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_LOAD) || (s == S_MEM_STORE);
    endfunction

endpackage

// File: rtl/rv_branch_eval.sv
// Branch condition from funct3 and the ALU compare flags.
module rv_branch_eval (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       taken
);

    // funct3[2] picks lt vs zero, funct3[0] inverts; 010/011 are not branches.
    always_comb begin
        taken = 1'b0;
        if (funct3[2:1] != 2'b01) begin
            taken = funct3[0] ^ (funct3[2] ? alu_lt : alu_zero);
        end
    end

endmodule

// File: rtl/rv_multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core with memory wait timeout and trap flags.
module rv_multicycle_control
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic        TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic             taken;
    logic             set_illegal;
    logic             set_bus_err;

    rv_branch_eval u_branch_eval (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .taken    (taken)
    );

    // Timeout fires when the counter has reached the limit; mem_ready is checked first by the FSM.
    assign timeout = TIMEOUT_EN && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    assign state_o = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter: counts stalled request cycles, cleared on completion or state exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (is_mem_state(state) && !mem_ready && (next_state == state)) begin
            if (wait_cnt != {CNT_W{1'b1}}) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky trap flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            if (set_illegal) illegal_instr <= 1'b1;
            if (set_bus_err) bus_error     <= 1'b1;
        end
    end

    // Next-state and output decode; strobes are held low while reset is asserted.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_ADD;

        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_RTYPE:           next_state = S_EXEC_R;
                    OP_ITYPE:           next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
                    OP_BRANCH:          next_state = S_BRANCH;
                    OP_JAL:             next_state = S_JAL;
                    OP_JALR:            next_state = S_JALR;
                    OP_LUI:             next_state = S_LUI;
                    OP_AUIPC:           next_state = S_AUIPC;
                    OP_FENCE:           next_state = S_FETCH;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_RTYPE;
                next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_ITYPE;
                next_state = S_WB_ALU;
            end
            S_LUI: begin
                alu_src_a  = SRC_A_ZERO;
                alu_src_b  = SRC_B_IMM;
                next_state = S_WB_ALU;
            end
            S_AUIPC: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_IMM;
                next_state = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = opcode[5] ? S_MEM_STORE : S_MEM_LOAD;
            end
            S_MEM_LOAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    next_state = S_WB_MEM;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_MEM_STORE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                next_state = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_BRANCH;
                pc_src     = 1'b1;
                pc_write   = taken;
                next_state = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                result_src = RES_PC;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                next_state = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Directed bench for rv_multicycle_control: per-cycle vector table plus trap/timeout/reset sequences.
module tb_rv_multicycle_control;
    import rv32i_pkg::*;

    typedef struct packed {
        logic       mr, mw, iord, irw, pcw, pcs, rw;
        logic [1:0] rs, sa, sb, aop;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, lt, rdy;
        state_t     st;
        ctl_t       ctl;
    } vec_t;

    // Hand-derived control bundles: {mr mw iord irw pcw pcs rw, result_src, src_a, src_b, alu_op}
    localparam ctl_t E_FETCH  = {7'b1001100, 2'b00, 2'b00, 2'b10, 2'b00};
    localparam ctl_t E_FWAIT  = {7'b1000000, 2'b00, 2'b00, 2'b10, 2'b00};
    localparam ctl_t E_DECODE = {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam ctl_t E_EXEC_R = {7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10};
    localparam ctl_t E_EXEC_I = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b11};
    localparam ctl_t E_LUI    = {7'b0000000, 2'b00, 2'b11, 2'b01, 2'b00};
    localparam ctl_t E_AUIPC  = {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam ctl_t E_WB_ALU = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam ctl_t E_MADDR  = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00};
    localparam ctl_t E_MLOAD  = {7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam ctl_t E_WB_MEM = {7'b0000001, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam ctl_t E_MSTORE = {7'b0110000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam ctl_t E_BR_T   = {7'b0000110, 2'b00, 2'b10, 2'b00, 2'b01};
    localparam ctl_t E_BR_N   = {7'b0000010, 2'b00, 2'b10, 2'b00, 2'b01};
    localparam ctl_t E_JAL    = {7'b0000111, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam ctl_t E_JALR   = {7'b0000101, 2'b10, 2'b10, 2'b01, 2'b00};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal_instr, bus_error;
    logic [3:0] state_o;
    ctl_t       dut_ctl;
    logic [4:0] strobes;

    int total  = 0;
    int passed = 0;
    vec_t vecs[$];

    rv_multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .alu_zero      (alu_zero),
        .alu_lt        (alu_lt),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    assign dut_ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write,
                      result_src, alu_src_a, alu_src_b, alu_op};
    assign strobes = {mem_read, mem_write, ir_write, pc_write, reg_write};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                input logic lt, input logic rdy, input state_t st, input ctl_t c);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.lt = lt; v.rdy = rdy; v.st = st; v.ctl = c;
        return v;
    endfunction

    task automatic add_alu(input logic [6:0] op, input state_t ex_st, input ctl_t ex_c);
        vecs.push_back(mk(op, 3'b000, 1'b0, 1'b0, 1'b1, S_FETCH,  E_FETCH));
        vecs.push_back(mk(op, 3'b000, 1'b0, 1'b0, 1'b1, S_DECODE, E_DECODE));
        vecs.push_back(mk(op, 3'b000, 1'b0, 1'b0, 1'b1, ex_st,    ex_c));
        vecs.push_back(mk(op, 3'b000, 1'b0, 1'b0, 1'b1, S_WB_ALU, E_WB_ALU));
    endtask

    task automatic add_3cyc(input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input logic lt, input state_t st, input ctl_t c);
        vecs.push_back(mk(op, f3, z, lt, 1'b1, S_FETCH,  E_FETCH));
        vecs.push_back(mk(op, f3, z, lt, 1'b1, S_DECODE, E_DECODE));
        vecs.push_back(mk(op, f3, z, lt, 1'b1, st,       c));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, " rst state"}, 32'(state_o), 32'(S_FETCH));
        check({tag, " rst strobes"}, 32'(strobes), 32'd0);
        check({tag, " rst illegal"}, 32'(illegal_instr), 32'd0);
        check({tag, " rst bus_error"}, 32'(bus_error), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; opcode = OP_RTYPE; funct3 = 3'b000;
        alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b1;

        // Vector table: R-type first, then each instruction class.
        add_alu(OP_RTYPE, S_EXEC_R, E_EXEC_R);
        vecs.push_back(mk(OP_ITYPE, 3'b000, 1'b0, 1'b0, 1'b0, S_FETCH, E_FWAIT));
        add_alu(OP_ITYPE, S_EXEC_I, E_EXEC_I);
        add_alu(OP_LUI,   S_LUI,    E_LUI);
        add_alu(OP_AUIPC, S_AUIPC,  E_AUIPC);
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, S_FETCH,    E_FETCH));
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, S_DECODE,   E_DECODE));
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_ADDR, E_MADDR));
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_LOAD, E_MLOAD));
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_LOAD, E_MLOAD));
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_LOAD, E_MLOAD));
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, S_MEM_LOAD, E_MLOAD));
        vecs.push_back(mk(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, S_WB_MEM,   E_WB_MEM));
        vecs.push_back(mk(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, S_FETCH,     E_FETCH));
        vecs.push_back(mk(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, S_DECODE,    E_DECODE));
        vecs.push_back(mk(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, S_MEM_ADDR,  E_MADDR));
        vecs.push_back(mk(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, S_MEM_STORE, E_MSTORE));
        add_3cyc(OP_BRANCH, 3'b000, 1'b1, 1'b0, S_BRANCH, E_BR_T);  // BEQ equal
        add_3cyc(OP_BRANCH, 3'b000, 1'b0, 1'b0, S_BRANCH, E_BR_N);  // BEQ not equal
        add_3cyc(OP_BRANCH, 3'b001, 1'b1, 1'b0, S_BRANCH, E_BR_N);  // BNE equal
        add_3cyc(OP_BRANCH, 3'b110, 1'b0, 1'b1, S_BRANCH, E_BR_T);  // BLTU lt
        add_3cyc(OP_BRANCH, 3'b111, 1'b0, 1'b1, S_BRANCH, E_BR_N);  // BGEU lt
        add_3cyc(OP_BRANCH, 3'b101, 1'b1, 1'b0, S_BRANCH, E_BR_T);  // BGE not lt
        add_3cyc(OP_BRANCH, 3'b010, 1'b0, 1'b1, S_BRANCH, E_BR_N);  // 010 never taken
        add_3cyc(OP_BRANCH, 3'b011, 1'b1, 1'b0, S_BRANCH, E_BR_N);  // 011 never taken
        add_3cyc(OP_JAL,  3'b000, 1'b0, 1'b0, S_JAL,  E_JAL);
        add_3cyc(OP_JALR, 3'b000, 1'b0, 1'b0, S_JALR, E_JALR);
        vecs.push_back(mk(OP_FENCE, 3'b000, 1'b0, 1'b0, 1'b1, S_FETCH,  E_FETCH));
        vecs.push_back(mk(OP_FENCE, 3'b000, 1'b0, 1'b0, 1'b1, S_DECODE, E_DECODE));

        // Initial reset.
        #2 rst_n = 1'b0;
        #1;
        check("init state", 32'(state_o), 32'(S_FETCH));
        check("init strobes", 32'(strobes), 32'd0);
        check("init flags", 32'({illegal_instr, bus_error}), 32'd0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct3 = vecs[i].f3;
            alu_zero = vecs[i].z; alu_lt = vecs[i].lt; mem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("row%0d ctl", i), 32'(dut_ctl), 32'(vecs[i].ctl));
            tick();
        end

        // FENCE returned to fetch; illegal opcode traps.
        opcode = 7'b1110011; mem_ready = 1'b1;
        @(negedge clk);
        check("fence->fetch", 32'(state_o), 32'(S_FETCH));
        tick();
        @(negedge clk);
        check("trap decode", 32'(state_o), 32'(S_DECODE));
        tick();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("trap c%0d state", c), 32'(state_o), 32'(S_TRAP));
            check($sformatf("trap c%0d strobes", c), 32'(strobes), 32'd0);
            check($sformatf("trap c%0d illegal", c), 32'(illegal_instr), 32'd1);
            tick();
        end
        reset_pulse("trap");

        // Fetch timeout: five stalled cycles with MEM_TIMEOUT=4.
        opcode = OP_STORE; mem_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("to wait%0d state", c), 32'(state_o), 32'(S_FETCH));
            check($sformatf("to wait%0d bus_error", c), 32'(bus_error), 32'd0);
            tick();
        end
        check("to trap state", 32'(state_o), 32'(S_TRAP));
        check("to bus_error", 32'(bus_error), 32'd1);
        check("to strobes", 32'(strobes), 32'd0);
        reset_pulse("to");

        // Ready on wait cycle 5 wins over the timeout.
        for (int c = 1; c <= 5; c++) begin
            mem_ready = (c == 5);
            @(negedge clk);
            check($sformatf("late%0d ir_write", c), 32'(ir_write), 32'(c == 5));
            tick();
        end
        mem_ready = 1'b0;
        check("late decode", 32'(state_o), 32'(S_DECODE));
        check("late bus_error", 32'(bus_error), 32'd0);
        tick();
        tick();
        @(negedge clk);
        check("store mem_write", 32'(mem_write), 32'd1);
        check("store state", 32'(state_o), 32'(S_MEM_STORE));

        // Async reset in the middle of the store cycle.
        #1 rst_n = 1'b0;
        #1;
        check("async mem_write", 32'(mem_write), 32'd0);
        check("async state", 32'(state_o), 32'(S_FETCH));
        check("async mem_read", 32'(mem_read), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("post-rst fetch", 32'(mem_read), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
